csa_resolver: RTL

Multi-cycle carry-propagate resolver for carry-save results. It accepts a redundant (Sum, Cout) vector pair from the 3:2 carry-save stage, where Cout is already left-shifted and Cout[0]=0. It produces the binary value Sum+Cout and the final carry-out. The addition is done in CHUNK-bit slices, one slice per cycle, with a ripple carry held between slices. It sits between the systolic PE accumulation tree and the result-collection path, behind valid/ready handshakes on both sides.

---
 rtl/csa_resolver.sv | 102 ++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save (sum, cout) pair into a binary value.
// The addition runs CHUNK bits per cycle, least significant slice first.
// A ripple carry is held between slices.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake; the pair is sampled only on the accept edge
//   sum_in, cout_in     carry-save vectors (cout_in is already weight-aligned)
//   out_valid/out_ready output handshake; result is held while out_valid=1
//   result, carry_out   (sum_in + cout_in) mod 2^WIDTH, and bit WIDTH of that sum
//
// state | meaning
// IDLE  | waiting for a pair; in_ready=1
// ADD   | resolving slice idx; one slice per cycle
// DONE  | result presented; waiting for out_ready
module csa_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep idx at least one bit wide so NCHUNK=1 still elaborates.
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] op_s, op_c;
    logic [CHUNK-1:0] slice_s, slice_c, slice_r;
    logic             slice_c_out;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;

    assign slice_s = op_s[idx*CHUNK +: CHUNK];
    assign slice_c = op_c[idx*CHUNK +: CHUNK];
    assign {slice_c_out, slice_r} = {1'b0, slice_s} + {1'b0, slice_c} + {{CHUNK{1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = ADD;
            ADD:  if (idx == LAST_IDX) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            op_s      <= '0;
            op_c      <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            op_s  <= sum_in;
            op_c  <= cout_in;
            idx   <= '0;
            carry <= 1'b0;
        end else if (state == ADD) begin
            result[idx*CHUNK +: CHUNK] <= slice_r;
            carry <= slice_c_out;
            if (idx == LAST_IDX) begin
                carry_out <= slice_c_out;
                idx       <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
